// File: rtl/cpu_pkg.sv
// Shared constants for the 16-bit core front end: command width, HLT decode fields, fetch FSM encoding.
package cpu_pkg;

  localparam int CMD_W = 16;

  localparam logic [1:0] OPC_CLASS_ALU = 2'b11;
  localparam logic [3:0] OP3_HLT       = 4'b1111;

  localparam logic [CMD_W-1:0] CMD_NOP = 16'h0000;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t FS_IDLE  = 2'd0;
  localparam fetch_state_t FS_FETCH = 2'd1;
  localparam fetch_state_t FS_FLUSH = 2'd2;
  localparam fetch_state_t FS_HALT  = 2'd3;

  function automatic logic is_hlt(input logic [CMD_W-1:0] c);
    return (c[15:14] == OPC_CLASS_ALU) && (c[7:4] == OP3_HLT);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Command handshake from fetch to decoder: cmd/cmd_pc qualified by cmd_valid, accepted on cmd_ready.
interface instr_fetch_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 12
) ();

  logic [CMD_W-1:0]  cmd;
  logic [ADDR_W-1:0] cmd_pc;
  logic              cmd_valid;
  logic              cmd_ready;

  modport master (output cmd, output cmd_pc, output cmd_valid, input  cmd_ready);
  modport slave  (input  cmd, input  cmd_pc, input  cmd_valid, output cmd_ready);

endinterface

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO of {cmd, pc}; head is read straight from storage, so it is already registered.
// Push beyond capacity is dropped unless a pop happens in the same cycle; flush wins over push/pop.
module fetch_skid_buf #(
  parameter int DW = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues 1-cycle imem reads into a 2-entry skid buffer feeding the decoder (rd_en -> cmd_valid: 2 cycles).
// cmd_ready low holds cmd and throttles issue; br_taken flushes everything. INSTR_FETCH_PERF_EN adds fetch_cnt/stall_cnt.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [CMD_W-1:0]  imem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  instr_fetch_if.master     cmd_if,
  output logic              halted
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] pc;
  } fetch_ent_t;

  localparam int ENT_W = $bits(fetch_ent_t);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ret_pc;
  logic              rd_pend;
  logic              discard;
  logic [1:0]        count;
  logic [ENT_W-1:0]  head_raw;
  fetch_ent_t        head;
  fetch_ent_t        ret_ent;
  logic              xfer;
  logic              hlt_xfer;
  logic              flush;
  logic              ret_live;
  logic              push;
  logic              issue;
  logic [2:0]        budget;

  assign xfer     = cmd_if.cmd_valid && cmd_if.cmd_ready;
  assign hlt_xfer = xfer && is_hlt(cmd_if.cmd);
  assign flush    = br_taken || hlt_xfer;
  assign ret_live = rd_pend && !discard;
  assign push     = ret_live && !flush;

  // Count the slot freed by this cycle's pop so a full-rate stream keeps issuing every cycle.
  assign budget = {1'b0, count} - {2'b0, xfer} + {2'b0, ret_live};
  assign issue  = (state == FS_FETCH) && (budget < 3'd2);

  assign imem_addr  = pc;
  assign imem_rd_en = issue;

  assign ret_ent = '{cmd: imem_rdata, pc: ret_pc};
  assign head    = fetch_ent_t'(head_raw);

  assign cmd_if.cmd       = head.cmd;
  assign cmd_if.cmd_pc    = head.pc;
  assign cmd_if.cmd_valid = (count != 2'd0);

  fetch_skid_buf #(
    .DW(ENT_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (ret_ent),
    .pop      (xfer),
    .flush    (flush),
    .count    (count),
    .head     (head_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FS_IDLE;
      pc      <= RESET_PC;
      ret_pc  <= '0;
      rd_pend <= 1'b0;
      discard <= 1'b0;
      halted  <= 1'b0;
    end else begin
      rd_pend <= issue;
      // A read launched in a flush cycle returns after the flush and must not land in the buffer.
      discard <= issue && flush;
      if (issue) ret_pc <= pc;

      if (br_taken) begin
        pc     <= br_target;
        state  <= FS_FLUSH;
        halted <= 1'b0;
      end else begin
        if (issue) pc <= pc + 1'b1;
        if (hlt_xfer) begin
          state  <= FS_HALT;
          halted <= 1'b1;
        end else begin
          case (state)
            FS_IDLE:  state <= FS_FETCH;
            FS_FLUSH: state <= FS_FETCH;
            default:  state <= state;
          endcase
        end
      end
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (xfer && (fetch_cnt != 32'hFFFF_FFFF)) fetch_cnt <= fetch_cnt + 32'd1;
      if (cmd_if.cmd_valid && !cmd_if.cmd_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: expected command stream derived from PC/branch/halt rules over a memory image.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd_en;
  logic [15:0]       imem_rdata = '0;
  logic              br_taken   = 1'b0;
  logic [ADDR_W-1:0] br_target  = '0;
  logic              halted;
`ifdef INSTR_FETCH_PERF_EN
  logic [31:0]       fetch_cnt;
  logic [31:0]       stall_cnt;
`endif

  instr_fetch_if #(.ADDR_W(ADDR_W)) cmd_if ();

  instr_fetch #(
    .ADDR_W   (ADDR_W),
    .RESET_PC ('0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_rd_en (imem_rd_en),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .cmd_if     (cmd_if),
    .halted     (halted)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [15:0] mem [DEPTH];
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [15:0]       cmd;
  } exp_t;

  exp_t              exp_q[$];
  logic [ADDR_W-1:0] model_pc   = '0;
  logic [ADDR_W-1:0] exp_issue  = '0;
  logic [ADDR_W-1:0] last_tgt   = '0;
  logic [ADDR_W-1:0] hold_pc    = '0;
  logic [15:0]       hold_cmd   = '0;
  bit                model_halted = 1'b0;
  bit                mon_en       = 1'b0;
  bit                hold_pend    = 1'b0;
  int                since_br   = 100;
  int                xfers      = 0;
  int                stalls     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit hlt_word(input logic [15:0] w);
    return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
  endfunction

  function automatic void refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{pc: model_pc, cmd: mem[model_pc]});
      model_pc = model_pc + 1'b1;
    end
  endfunction

  function automatic void model_restart(input logic [ADDR_W-1:0] start);
    exp_q.delete();
    model_pc     = start;
    exp_issue    = start;
    model_halted = 1'b0;
  endfunction

  // Monitor: samples each cycle's settled values at the falling edge, i.e. what the next rising edge will act on.
  always @(negedge clk) begin
    bit   v;
    bit   r;
    exp_t e;
    if (mon_en) begin
      v = cmd_if.cmd_valid;
      r = cmd_if.cmd_ready;
      if (since_br < 100) since_br++;
      check("halted", 32'(halted), 32'(model_halted));
      if (model_halted) begin
        check("halt_rd_en", 32'(imem_rd_en), 32'd0);
        check("halt_valid", 32'(v), 32'd0);
      end
      if (since_br >= 1 && since_br <= 3) check("flush_valid", 32'(v), 32'd0);
      if (since_br == 4) begin
        check("target_valid", 32'(v), 32'd1);
        check("target_pc", 32'(cmd_if.cmd_pc), 32'(last_tgt));
      end
      if (hold_pend) begin
        check("stall_valid", 32'(v), 32'd1);
        check("stall_cmd", 32'(cmd_if.cmd), 32'(hold_cmd));
        check("stall_pc", 32'(cmd_if.cmd_pc), 32'(hold_pc));
      end
      if (imem_rd_en) begin
        check("issue_addr", 32'(imem_addr), 32'(exp_issue));
        exp_issue = exp_issue + 1'b1;
      end
      if (v && r) begin
        xfers++;
        if (model_halted || exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL xfer_unexpected: got transfer of pc %0h, required none (t=%0t)", cmd_if.cmd_pc, $time);
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc", 32'(cmd_if.cmd_pc), 32'(e.pc));
          check("xfer_cmd", 32'(cmd_if.cmd), 32'(e.cmd));
          if (!br_taken && hlt_word(e.cmd)) begin
            model_halted = 1'b1;
            exp_q.delete();
          end
        end
      end
      if (v && !r) stalls++;
      hold_pend = v && !r && !br_taken;
      hold_cmd  = cmd_if.cmd;
      hold_pc   = cmd_if.cmd_pc;
      if (br_taken) begin
        last_tgt = br_target;
        since_br = 0;
        model_restart(br_target);
      end
      if (!model_halted) refill();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_br(input logic [ADDR_W-1:0] tgt);
    br_target = tgt;
    br_taken  = 1'b1;
    step();
    br_taken  = 1'b0;
    br_target = ADDR_W'($urandom());
  endtask

  initial begin
    logic [ADDR_W-1:0] tgt;
    cmd_if.cmd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 16) mem[i] = 16'h1000 + 16'(i);
      else        mem[i] = 16'($urandom()) & 16'hBFFF;
    end
    mem[100] = 16'hC5F3;
    mem[101] = 16'hC0E0;
    mem[102] = 16'h80F0;

    repeat (3) step();
    @(negedge clk);
    check("rst_rd_en", 32'(imem_rd_en), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_cmd", 32'(cmd_if.cmd), 32'h0000);
    check("rst_cmd_pc", 32'(cmd_if.cmd_pc), 32'd0);
    check("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
`ifdef INSTR_FETCH_PERF_EN
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    step();
    model_restart('0);
    refill();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    // Release cycle is IDLE, next cycle issues PC 0, data is buffered two cycles later.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_latency_valid", 32'(cmd_if.cmd_valid), 32'(k == 3));
    end
    check("first_cmd", 32'(cmd_if.cmd), 32'h1000);
    check("first_pc", 32'(cmd_if.cmd_pc), 32'd0);

    for (int k = 0; k < 40 && !(cmd_if.cmd_valid && cmd_if.cmd_pc == 4); k++) step();
    check("stall_start_pc", 32'(cmd_if.cmd_pc), 32'd4);
    cmd_if.cmd_ready = 1'b0;
    repeat (5) step();
    cmd_if.cmd_ready = 1'b1;
    check("stall_cycles", 32'(stalls), 32'd5);
`ifdef INSTR_FETCH_PERF_EN
    check("stall_cnt", stall_cnt, 32'd5);
`endif
    repeat (4) step();

    cmd_if.cmd_ready = 1'b0;
    repeat (3) step();
    cmd_if.cmd_ready = 1'b1;
    pulse_br(12'h020);
    repeat (8) step();

    cmd_if.cmd_ready = 1'b0;
    repeat (3) step();
    pulse_br(12'h040);
    cmd_if.cmd_ready = 1'b1;
    repeat (8) step();

    mem[7] = 16'hC0F0;
    pulse_br(12'h000);
    for (int k = 0; k < 40 && !halted; k++) step();
    check("halt_reached", 32'(halted), 32'd1);
    repeat (10) step();
    mem[7] = 16'h1007;
    pulse_br(12'h000);
    check("halt_cleared", 32'(halted), 32'd0);
    repeat (12) step();

    pulse_br(12'hFFD);
    repeat (12) step();

    for (int n = 0; n < 2000; n++) begin
      cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        tgt = $urandom_range(0, 1) ? ADDR_W'($urandom_range(90, 104)) : ADDR_W'($urandom());
        pulse_br(tgt);
      end else begin
        step();
      end
    end

    cmd_if.cmd_ready = 1'b1;
    pulse_br(12'h000);
    repeat (20) step();
`ifdef INSTR_FETCH_PERF_EN
    check("fetch_cnt", fetch_cnt, 32'(xfers));
    check("stall_cnt_total", stall_cnt, 32'(stalls));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    mismatched++;
    $display("FAIL watchdog: got no completion by t=%0t, required finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "watchdog expired");
  end

endmodule
